// File: rtl/ps2_mouse_decoder.sv
// ps2_mouse_decoder
//
// Turns a raw PS/2 mouse stream into an absolute, saturating X position and
// the left-button level. Both pins are synchronized, ps2_clk is debounced,
// 11-bit frames are deframed on filtered falling edges, and 3-byte movement
// packets are assembled. Each accepted packet adds its signed X delta to the
// position.
//
// Parameters
//   FILTER_LEN  consecutive equal samples before filtered ps2_clk moves (1..15)
//   TIMEOUT     cycles without a falling edge that abort a frame in progress
//   X_MAX       upper saturation limit of mouse_x
//
// Ports
//   clock           system clock, all logic on posedge
//   reset_          asynchronous active-low reset
//   ps2_clk         raw PS/2 clock pin (asynchronous, idle high)
//   ps2_dat         raw PS/2 data pin (asynchronous, idle high)
//   mouse_x         absolute X position
//   mouse_pressed_  0 while the left button is held
//   packet_valid    one-cycle pulse when a packet is accepted
//   frame_error     one-cycle pulse on parity, stop or timeout error
//
// Bit FSM states
//   state    | meaning
//   S_IDLE   | waiting for a start bit (data low on a falling edge)
//   S_DATA   | shifting in 8 data bits, LSB first
//   S_PARITY | capturing the parity bit
//   S_STOP   | checking stop bit and odd parity, handing byte to packet stage

module ps2_mouse_decoder #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 2000,
  parameter logic [15:0] X_MAX      = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [15:0] mouse_x,
  output logic        mouse_pressed_,
  output logic        packet_valid,
  output logic        frame_error
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [3:0]    FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Input synchronizers
  logic clk_s1, clk_s2;
  logic dat_s1, dat_s2;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // Clock filter: filt_cnt counts consecutive synchronized samples that
  // disagree with the filtered value; any agreeing sample restarts the count,
  // so short glitches never reach filt_clk.
  logic       filt_clk;
  logic       filt_prev;
  logic [3:0] filt_cnt;
  logic       fall;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= 4'd0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= 4'd0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s2;
        filt_cnt <= 4'd0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  // Frame / packet state
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic [1:0]    byte_idx;
  logic          left;
  logic          x_sign;
  logic          x_ovf;
  logic [7:0]    dx_byte;

  // Stop bit must be 1 and data+parity must carry an odd number of ones.
  logic frame_ok;
  assign frame_ok = dat_s2 & (^{shift, par_bit});

  // Saturating position update, evaluated in 18 bits so both the negative
  // and the above-X_MAX cases are visible.
  logic [17:0] sum;
  logic [15:0] x_next;

  always_comb begin
    sum = {2'b00, mouse_x} + {{9{x_sign}}, x_sign, dx_byte};
    if (sum[17]) begin
      x_next = 16'd0;
    end else if (sum[16:0] > {1'b0, X_MAX}) begin
      x_next = X_MAX;
    end else begin
      x_next = sum[15:0];
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state          <= S_IDLE;
      bit_cnt        <= 3'd0;
      shift          <= 8'd0;
      par_bit        <= 1'b0;
      tcnt           <= '0;
      byte_idx       <= 2'd0;
      left           <= 1'b0;
      x_sign         <= 1'b0;
      x_ovf          <= 1'b0;
      dx_byte        <= 8'd0;
      mouse_x        <= 16'd0;
      mouse_pressed_ <= 1'b1;
      packet_valid   <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      frame_error  <= 1'b0;

      if (fall) begin
        tcnt <= '0;
        case (state)
          S_IDLE: begin
            if (!dat_s2) begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= dat_s2;
            state   <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            if (frame_ok) begin
              case (byte_idx)
                2'd0: begin
                  // bit3 is always set in a real header byte; anything else
                  // means we are out of step, so drop it and wait.
                  if (shift[3]) begin
                    left     <= shift[0];
                    x_sign   <= shift[4];
                    x_ovf    <= shift[6];
                    byte_idx <= 2'd1;
                  end
                end
                2'd1: begin
                  dx_byte  <= shift;
                  byte_idx <= 2'd2;
                end
                default: begin
                  packet_valid   <= 1'b1;
                  mouse_pressed_ <= ~left;
                  if (!x_ovf) mouse_x <= x_next;
                  byte_idx       <= 2'd0;
                end
              endcase
            end else begin
              frame_error <= 1'b1;
              byte_idx    <= 2'd0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        if (tcnt == TO_LAST) begin
          state       <= S_IDLE;
          byte_idx    <= 2'd0;
          frame_error <= 1'b1;
          tcnt        <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule
